// File: rtl/hour_units_ctrl.sv
// Hours stage of the 12-hour clock: units-of-hours BCD digit, AM/PM flag,
// and the load/up/enable controls of the 1-bit tens-of-hours counter.
// Advances come from the minutes carry in run mode, or from a synchronized
// push button with auto-repeat in set mode.
module hour_units_ctrl #(
    parameter int unsigned REPEAT_DELAY  = 16,
    parameter int unsigned REPEAT_PERIOD = 4
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       Enable,
    input  logic       Carry_In,
    input  logic       Set_Mode,
    input  logic       Set_Inc,
    input  logic       TENS,
    output logic [3:0] UNITS,
    output logic       PM,
    output logic       TENS_EN,
    output logic       TENS_LD,
    output logic       TENS_IN,
    output logic       TENS_UP
);

    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       units_q, units_d;
    logic             pm_q, pm_d;
    logic [1:0]       sync_q, sync_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rep_q, rep_d;

    logic             btn_level_c;
    logic             edge_c;
    logic             rep_pulse_c;
    logic [CNT_W-1:0] target_c;
    logic             req_c;
    logic             adv_c;

    // State registers, all cleared by the shared asynchronous clear.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q <= ST_INIT;
            units_q <= 4'd2;
            pm_q    <= 1'b0;
            sync_q  <= 2'b00;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            units_q <= units_d;
            pm_q    <= pm_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
        end
    end

    // Button path: 2-FF synchronizer, rising-edge detect, auto-repeat counter.
    // cnt_q == 0 means idle; otherwise it counts cycles since the last pulse
    // and fires when it reaches the delay (first repeat) or the period.
    always_comb begin
        sync_d      = {sync_q[0], Set_Inc};
        prev_d      = sync_q[1];
        btn_level_c = sync_q[1];
        edge_c      = btn_level_c & ~prev_q;
        target_c    = rep_q ? CNT_W'(REPEAT_PERIOD) : CNT_W'(REPEAT_DELAY);
        rep_pulse_c = Set_Mode & btn_level_c & (cnt_q != '0) & (cnt_q == target_c);
        cnt_d       = cnt_q;
        rep_d       = rep_q;
        if (!Set_Mode || !btn_level_c) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (edge_c) begin
            cnt_d = CNT_W'(1);
            rep_d = 1'b0;
        end else if (rep_pulse_c) begin
            cnt_d = CNT_W'(1);
            rep_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Advance request selection; coincident edge and repeat pulses merge into one.
    always_comb begin
        req_c = Set_Mode ? (edge_c | rep_pulse_c) : Carry_In;
        adv_c = (state_q == ST_RUN) & Enable & req_c;
    end

    // Next-state, digit stepping and tens-counter strobes.
    always_comb begin
        state_d = state_q;
        units_d = units_q;
        pm_d    = pm_q;
        TENS_EN = 1'b0;
        TENS_LD = 1'b0;
        TENS_IN = 1'b0;
        TENS_UP = 1'b0;
        case (state_q)
            ST_INIT: begin
                state_d = ST_RUN;
                units_d = 4'd2;
                pm_d    = 1'b0;
                // Held-off while Clr is low so the strobes read 0 during reset.
                if (Enable && Clr) begin
                    TENS_EN = 1'b1;
                    TENS_LD = 1'b1;
                    TENS_IN = 1'b1;
                end
            end
            ST_RUN: begin
                if (adv_c) begin
                    if (!TENS && units_q == 4'd9) begin
                        units_d = 4'd0;
                        TENS_EN = 1'b1;
                        TENS_UP = 1'b1;
                    end else if (TENS && units_q == 4'd1) begin
                        units_d = 4'd2;
                        pm_d    = ~pm_q;
                    end else if (TENS && units_q == 4'd2) begin
                        units_d = 4'd1;
                        TENS_EN = 1'b1;
                        TENS_LD = 1'b1;
                    end else if ((!TENS && units_q >= 4'd1 && units_q <= 4'd8) ||
                                 (TENS && units_q == 4'd0)) begin
                        units_d = units_q + 4'd1;
                    end else begin
                        // Illegal digit pair: recover to 01, AM/PM kept.
                        units_d = 4'd1;
                        TENS_EN = 1'b1;
                        TENS_LD = 1'b1;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign UNITS = units_q;
    assign PM    = pm_q;

endmodule

// File: tb/tb_hour_units_ctrl.sv
// Bench for hour_units_ctrl: models the display as an hour number 1..12 plus
// AM/PM, models the external 1-bit tens counter, and predicts button advances
// from the press timing (edge n+2, then delay, then period).
module tb_hour_units_ctrl;

    localparam int unsigned D = 16;
    localparam int unsigned P = 4;

    logic       Clk = 1'b0;
    logic       Clr = 1'b1;
    logic       Enable = 1'b1;
    logic       Carry_In = 1'b0;
    logic       Set_Mode = 1'b0;
    logic       Set_Inc = 1'b0;
    logic       TENS;
    logic [3:0] UNITS;
    logic       PM;
    logic       TENS_EN;
    logic       TENS_LD;
    logic       TENS_IN;
    logic       TENS_UP;

    logic tens_m;
    logic tens_force = 1'b0;

    int checks = 0;
    int errors = 0;
    int hour   = 12;
    bit pm     = 1'b0;

    hour_units_ctrl #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
        .Clk(Clk), .Clr(Clr), .Enable(Enable), .Carry_In(Carry_In),
        .Set_Mode(Set_Mode), .Set_Inc(Set_Inc), .TENS(TENS),
        .UNITS(UNITS), .PM(PM), .TENS_EN(TENS_EN), .TENS_LD(TENS_LD),
        .TENS_IN(TENS_IN), .TENS_UP(TENS_UP)
    );

    always #5 Clk = ~Clk;

    // External tens-of-hours counter.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) tens_m <= 1'b0;
        else if (TENS_EN && TENS_LD) tens_m <= TENS_IN;
        else if (TENS_EN && TENS_UP) tens_m <= 1'b1;
    end

    assign TENS = tens_m | tens_force;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] strobes();
        return 8'({TENS_EN, TENS_LD, TENS_IN, TENS_UP});
    endfunction

    // One clock cycle: drive at negedge, check strobes, step model at posedge, check display.
    task automatic tick(input logic carry, input logic sinc, input logic en,
                        input logic sm, input bit exp_adv);
        logic [3:0] exp_str;
        @(negedge Clk);
        Carry_In = carry;
        Set_Inc  = sinc;
        Enable   = en;
        Set_Mode = sm;
        #1;
        exp_str = 4'b0000;
        if (exp_adv) begin
            if (hour == 9)       exp_str = 4'b1001;
            else if (hour == 12) exp_str = 4'b1100;
        end
        check("strobes", strobes(), 8'(exp_str));
        @(posedge Clk);
        if (exp_adv) begin
            if (hour == 11) pm = ~pm;
            hour = (hour % 12) + 1;
        end
        #1;
        check("units", 8'(UNITS), 8'(hour % 10));
        check("pm", 8'(PM), 8'(pm));
        check("tens", 8'(tens_m), 8'(hour >= 10));
    endtask

    // Set-mode press held for len cycles, followed by idle cycles.
    task automatic press(input int len, input bit rand_carry);
        bit adv;
        for (int i = 0; i < len + 4; i++) begin
            adv = (i <= len + 1) &&
                  ((i == 2) || (i >= 2 + int'(D) && ((i - 2 - int'(D)) % int'(P)) == 0));
            tick(rand_carry ? 1'($urandom_range(0, 1)) : 1'b0, (i < len), 1'b1, 1'b1, adv);
        end
    endtask

    // Clr release and the single INIT cycle.
    task automatic do_init(input logic carry);
        @(negedge Clk);
        Clr      = 1'b1;
        Carry_In = carry;
        Enable   = 1'b1;
        Set_Mode = 1'b0;
        Set_Inc  = 1'b0;
        #1;
        check("init_strobes", strobes(), 8'(4'b1110));
        @(posedge Clk);
        hour = 12;
        pm   = 1'b0;
        #1;
        check("init_units", 8'(UNITS), 8'd2);
        check("init_pm", 8'(PM), 8'd0);
        check("init_tens", 8'(tens_m), 8'd1);
    endtask

    initial begin
        // Reset held for three cycles.
        #1 Clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            #1;
            check("rst_units", 8'(UNITS), 8'd2);
            check("rst_pm", 8'(PM), 8'd0);
            check("rst_strobes", strobes(), 8'd0);
        end
        do_init(1'b0);

        // Full AM/PM cycle: 24 carries back to 12 AM.
        for (int i = 0; i < 24; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("cycle_units", 8'(UNITS), 8'd2);
        check("cycle_pm", 8'(PM), 8'd0);

        // Auto-repeat: held 40 cycles from 12 AM ends at 07.
        press(40, 1'b0);
        check("repeat_units", 8'(UNITS), 8'd7);

        // Single short press with concurrent carries: exactly one advance.
        press(2, 1'b1);

        // Button already held when set mode rises: no advance until re-pressed.
        for (int i = 0; i < 4; i++)  tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)  tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        press(2, 1'b0);

        // Set mode dropped mid-hold clears the repeat counter.
        for (int i = 0; i < 30; i++)
            tick(1'b0, 1'b1, 1'b1, !(i == 8 || i == 9), (i == 2));
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Enable gating: carries dropped, no strobes.
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random run-mode carries with random enable.
        for (int i = 0; i < 60; i++) begin
            logic c, e;
            c = ($urandom % 3) == 0;
            e = ($urandom % 4) != 0;
            tick(c, 1'($urandom_range(0, 1)), e, 1'b0, c & e);
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Random set-mode presses.
        for (int r = 0; r < 5; r++) press(int'($urandom_range(1, 30)), 1'b1);

        // Illegal recovery: tens forced to 1 while units is 5.
        for (int k = 0; k < 30 && hour != 5; k++) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge Clk);
        tens_force = 1'b1;
        Carry_In   = 1'b1;
        Enable     = 1'b1;
        Set_Mode   = 1'b0;
        Set_Inc    = 1'b0;
        #1;
        check("ill_strobes", strobes(), 8'(4'b1100));
        @(posedge Clk);
        #1;
        tens_force = 1'b0;
        hour = 1;
        check("ill_units", 8'(UNITS), 8'd1);
        check("ill_pm", 8'(PM), 8'(pm));
        check("ill_tens", 8'(tens_m), 8'd0);

        // Move to 12 PM, then clear in the same cycle as a carry.
        for (int k = 0; k < 30 && !(hour == 12 && pm); k++) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("pm_before_clr", 8'(PM), 8'd1);
        @(negedge Clk);
        Carry_In = 1'b1;
        Clr      = 1'b0;
        #1;
        check("clr_units", 8'(UNITS), 8'd2);
        check("clr_pm", 8'(PM), 8'd0);
        check("clr_strobes", strobes(), 8'd0);
        @(posedge Clk);
        #1;
        check("clr_hold_units", 8'(UNITS), 8'd2);
        check("clr_hold_strobes", strobes(), 8'd0);

        // INIT reruns and ignores a carry present during it.
        do_init(1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
